// File: rtl/ctrl_pipe_hazard_if.sv
// ID-stage control inputs and EX/MEM/WB control outputs of the hazard/forwarding pipe.
// master = decoder/datapath side, slave = ctrl_pipe_hazard.
interface ctrl_pipe_hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
);
    logic                  RegDst_i;
    logic [ALUOP_W-1:0]    ALUOp_i;
    logic                  ALUSrc_i;
    logic                  RegWrite_i;
    logic                  MemToReg_i;
    logic                  MemWrite_i;
    logic                  IsBranch_i;
    logic                  BranchEq_i;
    logic [REG_ADDR_W-1:0] IdRs_i;
    logic [REG_ADDR_W-1:0] IdRt_i;
    logic [REG_ADDR_W-1:0] IdRd_i;

    logic [ALUOP_W-1:0]    ExALUOp_o;
    logic                  ExALUSrc_o;
    logic [REG_ADDR_W-1:0] ExRs_o;
    logic [REG_ADDR_W-1:0] ExRt_o;
    logic [1:0]            ForwardA_o;
    logic [1:0]            ForwardB_o;
    logic                  MemWrite_o;
    logic                  MemRead_o;
    logic                  WbRegWrite_o;
    logic                  WbMemToReg_o;
    logic [REG_ADDR_W-1:0] WbDst_o;
    logic                  Stall_o;
    logic                  Flush_o;

    modport master (
        output RegDst_i, ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i,
               IsBranch_i, BranchEq_i, IdRs_i, IdRt_i, IdRd_i,
        input  ExALUOp_o, ExALUSrc_o, ExRs_o, ExRt_o, ForwardA_o, ForwardB_o,
               MemWrite_o, MemRead_o, WbRegWrite_o, WbMemToReg_o, WbDst_o,
               Stall_o, Flush_o
    );

    modport slave (
        input  RegDst_i, ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i,
               IsBranch_i, BranchEq_i, IdRs_i, IdRt_i, IdRd_i,
        output ExALUOp_o, ExALUSrc_o, ExRs_o, ExRt_o, ForwardA_o, ForwardB_o,
               MemWrite_o, MemRead_o, WbRegWrite_o, WbMemToReg_o, WbDst_o,
               Stall_o, Flush_o
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipe ID/EX -> EX/MEM -> MEM/WB with load-use/branch stall, flush and EX forwarding; EX +1, MEM +2, WB +3.
// Stall_o holds PC and IF/ID and injects a bubble into ID/EX; later stages always advance.
module ctrl_pipe_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ctrl_pipe_hazard_if.slave bus
);

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic                  alusrc;
        logic                  we;
        logic                  ld;
        logic                  st;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        logic                  we;
        logic                  ld;
        logic                  st;
        logic [REG_ADDR_W-1:0] dst;
    } exmem_t;

    typedef struct packed {
        logic                  we;
        logic                  ld;
        logic [REG_ADDR_W-1:0] dst;
    } memwb_t;

    idex_t  ex_q,  ex_d;
    exmem_t mem_q, mem_d;
    memwb_t wb_q,  wb_d;

    logic [REG_ADDR_W-1:0] id_dst;
    logic ex_hit, mem_hit;
    logic mem_we_eff, wb_we_eff;
    logic ld_use, br_haz, stall;

    assign id_dst = bus.RegDst_i ? bus.IdRd_i : bus.IdRt_i;

    // Register 0 is hardwired, so it never creates a dependency.
    assign ex_hit  = (ex_q.dst  != '0) && ((ex_q.dst  == bus.IdRs_i) || (ex_q.dst  == bus.IdRt_i));
    assign mem_hit = (mem_q.dst != '0) && ((mem_q.dst == bus.IdRs_i) || (mem_q.dst == bus.IdRt_i));

    assign mem_we_eff = mem_q.we && (mem_q.dst != '0);
    assign wb_we_eff  = wb_q.we  && (wb_q.dst  != '0);

    assign ld_use = ex_q.ld && ex_hit;
    assign br_haz = bus.IsBranch_i && ((ex_q.we && ex_hit) || (mem_q.ld && mem_hit));
    assign stall  = !rst_i && (ld_use || br_haz);

    always_comb begin
        ex_d = '0;
        if (!stall) begin
            ex_d.aluop  = bus.ALUOp_i;
            ex_d.alusrc = bus.ALUSrc_i;
            ex_d.we     = bus.RegWrite_i && !bus.IsBranch_i;
            ex_d.ld     = bus.MemToReg_i;
            ex_d.st     = bus.MemWrite_i && !bus.IsBranch_i;
            ex_d.dst    = id_dst;
            ex_d.rs     = bus.IdRs_i;
            ex_d.rt     = bus.IdRt_i;
        end

        mem_d     = '0;
        mem_d.we  = ex_q.we;
        mem_d.ld  = ex_q.ld;
        mem_d.st  = ex_q.st;
        mem_d.dst = ex_q.dst;

        wb_d      = '0;
        wb_d.we   = mem_q.we;
        wb_d.ld   = mem_q.ld;
        wb_d.dst  = mem_q.dst;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // The younger result in EX/MEM wins over MEM/WB.
    always_comb begin
        bus.ForwardA_o = 2'b00;
        if (mem_we_eff && (mem_q.dst == ex_q.rs))
            bus.ForwardA_o = 2'b10;
        else if (wb_we_eff && (wb_q.dst == ex_q.rs))
            bus.ForwardA_o = 2'b01;

        bus.ForwardB_o = 2'b00;
        if (mem_we_eff && (mem_q.dst == ex_q.rt))
            bus.ForwardB_o = 2'b10;
        else if (wb_we_eff && (wb_q.dst == ex_q.rt))
            bus.ForwardB_o = 2'b01;
    end

    assign bus.ExALUOp_o    = ex_q.aluop;
    assign bus.ExALUSrc_o   = ex_q.alusrc;
    assign bus.ExRs_o       = ex_q.rs;
    assign bus.ExRt_o       = ex_q.rt;
    assign bus.MemWrite_o   = mem_q.st;
    assign bus.MemRead_o    = mem_q.ld;
    assign bus.WbRegWrite_o = wb_q.we;
    assign bus.WbMemToReg_o = wb_q.ld;
    assign bus.WbDst_o      = wb_q.dst;
    assign bus.Stall_o      = stall;
    assign bus.Flush_o      = !rst_i && bus.IsBranch_i && bus.BranchEq_i && !stall;

endmodule
